// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, FSM encoding and op-legality helper for the ALU arbiter
package alu_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] ADD  = 5'd4;
    localparam logic [OP_W-1:0] SUB  = 5'd5;
    localparam logic [OP_W-1:0] MUL  = 5'd6;
    localparam logic [OP_W-1:0] DIV  = 5'd7;
    localparam logic [OP_W-1:0] AND  = 5'd8;
    localparam logic [OP_W-1:0] NAND = 5'd9;
    localparam logic [OP_W-1:0] OR   = 5'd10;
    localparam logic [OP_W-1:0] XOR  = 5'd11;
    localparam logic [OP_W-1:0] CMP  = 5'd12;
    localparam logic [OP_W-1:0] NOT  = 5'd13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // XOR has a code but the ALU does not decode it, so it is not legal.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return ((op >= ADD) && (op <= OR)) || (op == CMP) || (op == NOT);
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU shared by the arbiter requesters
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH_DATA = 32
) (
    input  logic [OP_W-1:0]       op_code,
    input  logic [WIDTH_DATA-1:0] operand_a,
    input  logic [WIDTH_DATA-1:0] operand_b,
    output logic [WIDTH_DATA-1:0] result
);

    localparam logic [WIDTH_DATA-1:0] ONE = {{(WIDTH_DATA-1){1'b0}}, 1'b1};

    // Decode the op code; undecoded codes (XOR included) yield zero.
    always_comb begin
        result = '0;
        case (op_code)
            ADD:  result = operand_a + operand_b;
            SUB:  result = operand_a - operand_b;
            MUL:  result = operand_a * operand_b;
            DIV:  result = (operand_b == '0) ? '0 : operand_a / operand_b;
            AND:  result = operand_a & operand_b;
            NAND: result = ~(operand_a & operand_b);
            OR:   result = operand_a | operand_b;
            CMP:  begin
                if (operand_a < operand_b) begin
                    result = '1;
                end else if (operand_a == operand_b) begin
                    result = '0;
                end else begin
                    result = ONE;
                end
            end
            NOT:  result = ~operand_a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU between two requesters; option ALU_ARB_OPCHECK_EN
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH_DATA = 32,
    parameter int N_REQ      = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*OP_W-1:0]       req_op_code,
    input  logic [N_REQ*WIDTH_DATA-1:0] req_op_a,
    input  logic [N_REQ*WIDTH_DATA-1:0] req_op_b,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic                        resp_id,
    output logic [WIDTH_DATA-1:0]       resp_result,
    output logic                        resp_err,
    output logic                        busy
);

    state_t                  state;
    logic                    rr_ptr;
    logic                    grant_q;
    logic [OP_W-1:0]         op_q;
    logic [WIDTH_DATA-1:0]   a_q;
    logic [WIDTH_DATA-1:0]   b_q;
    logic [WIDTH_DATA-1:0]   alu_result;

    logic                    any_valid;
    logic                    grant_c;
    logic [OP_W-1:0]         sel_op;
    logic [WIDTH_DATA-1:0]   sel_a;
    logic [WIDTH_DATA-1:0]   sel_b;
    logic                    skip_exec;

    // Priority holder wins if it is asking, otherwise the other requester.
    assign any_valid = |req_valid;
    assign grant_c   = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;

    assign sel_op = grant_c ? req_op_code[2*OP_W-1:OP_W]             : req_op_code[OP_W-1:0];
    assign sel_a  = grant_c ? req_op_a[2*WIDTH_DATA-1:WIDTH_DATA]    : req_op_a[WIDTH_DATA-1:0];
    assign sel_b  = grant_c ? req_op_b[2*WIDTH_DATA-1:WIDTH_DATA]    : req_op_b[WIDTH_DATA-1:0];

`ifdef ALU_ARB_OPCHECK_EN
    assign skip_exec = ~is_legal_op(sel_op);
`else
    assign skip_exec = 1'b0;
`endif

    assign busy = (state != IDLE);

    // Accept strobe: only the granted requester, only while idle.
    always_comb begin
        req_ready = '0;
        if ((state == IDLE) && any_valid) begin
            req_ready[grant_c] = 1'b1;
        end
    end

    // The ALU only ever sees the latched operation, never the live request buses.
    alu #(
        .WIDTH_DATA (WIDTH_DATA)
    ) u_alu (
        .op_code   (op_q),
        .operand_a (a_q),
        .operand_b (b_q),
        .result    (alu_result)
    );

    // Control FSM: accept, execute, then hold the response until it is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            grant_q     <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant_q <= grant_c;
                        op_q    <= sel_op;
                        a_q     <= sel_a;
                        b_q     <= sel_b;
                        if (skip_exec) begin
                            state       <= RESP;
                            resp_valid  <= 1'b1;
                            resp_id     <= grant_c;
                            resp_result <= '0;
                            resp_err    <= 1'b1;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    state       <= RESP;
                    resp_valid  <= 1'b1;
                    resp_id     <= grant_q;
                    resp_result <= alu_result;
                    resp_err    <= 1'b0;
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        rr_ptr     <= ~grant_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter (vector table, corner sequences, random vs model)
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [9:0]  req_op_code;
    logic [63:0] req_op_a;
    logic [63:0] req_op_b;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [31:0] resp_result;
    logic        resp_err;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic exp_rr = 1'b0;

    alu_arbiter #(.WIDTH_DATA(32), .N_REQ(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op_code (req_op_code),
        .req_op_a    (req_op_a),
        .req_op_b    (req_op_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_err    (resp_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        string       name;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic legal(input logic [4:0] op);
        return ((op >= 5'd4) && (op <= 5'd10)) || (op == 5'd12) || (op == 5'd13);
    endfunction

    function automatic logic exp_err(input logic [4:0] op);
`ifdef ALU_ARB_OPCHECK_EN
        return !legal(op);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int exp_lat(input logic [4:0] op);
        return exp_err(op) ? 1 : 2;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned m  = 64'h1_0000_0000;
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        case (op)
            5'd4:  return 32'((ua + ub) % m);
            5'd5:  return 32'((ua + m - ub) % m);
            5'd6:  return 32'((ua * ub) % m);
            5'd7:  return (ub == 0) ? 32'd0 : 32'(ua / ub);
            5'd8:  return a & b;
            5'd9:  return ~(a & b);
            5'd10: return a | b;
            5'd12: return (ua < ub) ? 32'hFFFF_FFFF : ((ua == ub) ? 32'd0 : 32'd1);
            5'd13: return ~a;
            default: return 32'd0;
        endcase
    endfunction

    task automatic set_req(input int id, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (id == 0) begin
            req_op_code[4:0] = op; req_op_a[31:0] = a; req_op_b[31:0] = b;
        end else begin
            req_op_code[9:5] = op; req_op_a[63:32] = a; req_op_b[63:32] = b;
        end
    endtask

    task automatic scramble_req();
        req_op_code = 10'($urandom);
        req_op_a    = {$urandom, $urandom};
        req_op_b    = {$urandom, $urandom};
    endtask

    // Wait (bounded) for resp_valid; returns number of negedges waited.
    task automatic wait_resp(input string name, output int lat);
        lat = 1;
        @(negedge clk);
        while (!resp_valid && lat < 10) begin
            lat++;
            @(negedge clk);
        end
        if (!resp_valid) chk({name, ".timeout"}, 32'(resp_valid), 32'd1);
    endtask

    task automatic run_single(input int id, input logic [4:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] res, input string name);
        int lat;
        @(posedge clk); #1;
        req_valid = 2'b00;
        req_valid[id] = 1'b1;
        set_req(id, op, a, b);
        resp_ready = 1'b1;
        @(negedge clk);
        chk({name, ".ready"}, 32'(req_ready), 32'(2'b01 << id));
        @(posedge clk); #1;
        req_valid = 2'b00;
        scramble_req();
        wait_resp(name, lat);
        chk({name, ".lat"}, 32'(lat), 32'(exp_lat(op)));
        chk({name, ".id"}, 32'(resp_id), 32'(id));
        chk({name, ".res"}, resp_result, res);
        chk({name, ".err"}, 32'(resp_err), 32'(exp_err(op)));
        exp_rr = (id == 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({name, ".idle"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 2'b00;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_rr = 1'b0;
    endtask

    initial begin
        int lat;
        int got;
        int cyc;
        logic [1:0]  exp_ids[4];
        logic [31:0] exp_res[4];

        vecs[0]  = '{5'd4,  32'd7,          32'd5,          32'd12,         "add"};
        vecs[1]  = '{5'd4,  32'hFFFF_FFFF,  32'd2,          32'd1,          "add_wrap"};
        vecs[2]  = '{5'd5,  32'd3,          32'd5,          32'hFFFF_FFFE,  "sub_neg"};
        vecs[3]  = '{5'd5,  32'd10,         32'd3,          32'd7,          "sub"};
        vecs[4]  = '{5'd6,  32'd6,          32'd7,          32'd42,         "mul"};
        vecs[5]  = '{5'd6,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          "mul_wrap"};
        vecs[6]  = '{5'd7,  32'd100,        32'd7,          32'd14,         "div"};
        vecs[7]  = '{5'd7,  32'd100,        32'd0,          32'd0,          "div0"};
        vecs[8]  = '{5'd8,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  "and"};
        vecs[9]  = '{5'd9,  32'hFFFF_FFFF,  32'h0F0F_0F0F,  32'hF0F0_F0F0,  "nand"};
        vecs[10] = '{5'd10, 32'h0000_000F,  32'h0000_00F0,  32'h0000_00FF,  "or"};
        vecs[11] = '{5'd12, 32'd3,          32'd9,          32'hFFFF_FFFF,  "cmp_lt"};
        vecs[12] = '{5'd12, 32'd9,          32'd9,          32'd0,          "cmp_eq"};
        vecs[13] = '{5'd12, 32'd9,          32'd3,          32'd1,          "cmp_gt"};
        vecs[14] = '{5'd13, 32'd0,          32'd123,        32'hFFFF_FFFF,  "not"};
        vecs[15] = '{5'd11, 32'd6,          32'd3,          32'd0,          "xor"};
        vecs[16] = '{5'd3,  32'd6,          32'd3,          32'd0,          "op3"};
        vecs[17] = '{5'd31, 32'd6,          32'd3,          32'd0,          "op31"};

        rst_n = 1'b0;
        req_valid = 2'b00;
        resp_ready = 1'b0;
        req_op_code = '0;
        req_op_a = '0;
        req_op_b = '0;
        repeat (2) @(negedge clk);
        chk("reset.resp_valid", 32'(resp_valid), 32'd0);
        chk("reset.resp_id", 32'(resp_id), 32'd0);
        chk("reset.resp_result", resp_result, 32'd0);
        chk("reset.resp_err", 32'(resp_err), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;

        // Vector table; ids alternate so both slots are exercised.
        for (int i = 0; i < 18; i++) begin
            run_single(i % 2, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].name);
        end

        // Both requesters valid continuously: strict alternation starting with 0.
        do_reset();
        exp_ids = '{2'd0, 2'd1, 2'd0, 2'd1};
        exp_res = '{32'd7, 32'd42, 32'd7, 32'd42};
        @(posedge clk); #1;
        set_req(0, 5'd5, 32'd10, 32'd3);
        set_req(1, 5'd6, 32'd6, 32'd7);
        req_valid = 2'b11;
        resp_ready = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            chk("alt.ready_not_both", 32'(req_ready == 2'b11), 32'd0);
            if (resp_valid) begin
                chk($sformatf("alt.id%0d", got), 32'(resp_id), 32'(exp_ids[got]));
                chk($sformatf("alt.res%0d", got), resp_result, exp_res[got]);
                got++;
            end
        end
        chk("alt.count", 32'(got), 32'd4);
        @(posedge clk); #1;
        req_valid = 2'b00;
        exp_rr = 1'b0;

        // Backpressure: req1 DIV 100/0 held while req0 waits.
        @(posedge clk); #1;
        req_valid = 2'b10;
        set_req(1, 5'd7, 32'd100, 32'd0);
        resp_ready = 1'b0;
        @(negedge clk);
        chk("bp.ready", 32'(req_ready), 32'b10);
        @(posedge clk); #1;
        req_valid = 2'b01;
        set_req(0, 5'd4, 32'd1, 32'd2);
        wait_resp("bp", lat);
        chk("bp.lat", 32'(lat), 32'd2);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("bp.valid%0d", k), 32'(resp_valid), 32'd1);
            chk($sformatf("bp.res%0d", k), resp_result, 32'd0);
            chk($sformatf("bp.id%0d", k), 32'(resp_id), 32'd1);
            chk($sformatf("bp.ready%0d", k), 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp.idle_busy", 32'(busy), 32'd0);
        chk("bp.idle_valid", 32'(resp_valid), 32'd0);
        chk("bp.next_grant", 32'(req_ready), 32'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_resp("bp2", lat);
        chk("bp2.id", 32'(resp_id), 32'd0);
        chk("bp2.res", resp_result, 32'd3);
        exp_rr = 1'b1;
        @(posedge clk); #1;

        // Reset during EXEC of requester 1 with rr pointing at 1.
        run_single(0, 5'd4, 32'd1, 32'd1, 32'd2, "pre_rst");
        @(posedge clk); #1;
        req_valid = 2'b10;
        set_req(1, 5'd6, 32'd3, 32'd3);
        @(negedge clk);
        chk("rst.accept", 32'(req_ready), 32'b10);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        chk("rst.exec_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.valid", 32'(resp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_rr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rst.no_resp%0d", k), 32'(resp_valid), 32'd0);
        end
        @(posedge clk); #1;
        req_valid = 2'b11;
        set_req(0, 5'd4, 32'd2, 32'd2);
        set_req(1, 5'd4, 32'd5, 32'd5);
        resp_ready = 1'b1;
        @(negedge clk);
        chk("rst.first_grant", 32'(req_ready), 32'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_resp("rst2", lat);
        chk("rst2.id", 32'(resp_id), 32'd0);
        chk("rst2.res", resp_result, 32'd4);
        exp_rr = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic against a transaction-level model.
        begin
            logic        m_idle = 1'b1;
            logic        m_id = 1'b0;
            logic [31:0] m_res = '0;
            logic        m_err = 1'b0;
            int          m_lat = 0;
            int          m_wait = 0;
            int          n_done = 0;
            logic        g;
            logic [1:0]  exp_ready;
            logic [4:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            for (int c = 0; c < 800; c++) begin
                @(posedge clk); #1;
                for (int s = 0; s < 2; s++) begin
                    op = 5'($urandom_range(3, 14));
                    a = $urandom;
                    b = $urandom;
                    if (op == 5'd7 || op == 5'd12) begin
                        a = a & 32'h7FFF_FFFF;
                        b = b & 32'h7FFF_FFFF;
                        if ($urandom_range(0, 3) == 0) b = (op == 5'd7) ? 32'd0 : a;
                    end
                    set_req(s, op, a, b);
                end
                req_valid = 2'($urandom_range(0, 3));
                resp_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (m_idle) begin
                    exp_ready = 2'b00;
                    g = req_valid[exp_rr] ? exp_rr : ~exp_rr;
                    if (req_valid != 2'b00) exp_ready[g] = 1'b1;
                    chk("rnd.ready", 32'(req_ready), 32'(exp_ready));
                    chk("rnd.idle_busy", 32'(busy), 32'd0);
                    chk("rnd.idle_valid", 32'(resp_valid), 32'd0);
                    if (req_valid != 2'b00) begin
                        op = g ? req_op_code[9:5] : req_op_code[4:0];
                        a  = g ? req_op_a[63:32] : req_op_a[31:0];
                        b  = g ? req_op_b[63:32] : req_op_b[31:0];
                        m_res  = ref_alu(op, a, b);
                        m_err  = exp_err(op);
                        m_lat  = exp_lat(op);
                        m_id   = g;
                        m_wait = 0;
                        m_idle = 1'b0;
                    end
                end else begin
                    m_wait++;
                    chk("rnd.busy", 32'(busy), 32'd1);
                    chk("rnd.ready_busy", 32'(req_ready), 32'd0);
                    if (m_wait < m_lat) begin
                        chk("rnd.early_valid", 32'(resp_valid), 32'd0);
                    end else begin
                        chk("rnd.valid", 32'(resp_valid), 32'd1);
                        chk("rnd.id", 32'(resp_id), 32'(m_id));
                        chk("rnd.res", resp_result, m_res);
                        chk("rnd.err", 32'(resp_err), 32'(m_err));
                        if (resp_ready) begin
                            exp_rr = ~m_id;
                            m_idle = 1'b1;
                            n_done++;
                        end
                    end
                end
            end
            chk("rnd.progress", 32'(n_done > 50), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
